// File: rtl/vga_arb_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Package   : vga_arb_pkg                                            |
// | Purpose   : Shared types and constants for the VGA/CPU RAM         |
// |             arbiter (CPU FSM state encoding, default bus widths,   |
// |             stall counter width).                                  |
// | Revision  : 1.0 - initial release                                  |
// +--------------------------------------------------------------------+
package vga_arb_pkg;

  localparam int AW_DEF      = 16;
  localparam int DW_DEF      = 8;
  localparam int STALL_CNT_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PEND = 2'd1,
    ACK  = 2'd2
  } cpu_state_t;

endpackage : vga_arb_pkg
`default_nettype wire

// File: rtl/vga_arb_sat_cnt.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module    : vga_arb_sat_cnt                                        |
// | Purpose   : Up-counter that sticks at all-ones, with a synchronous |
// |             clear that takes priority over the enable.             |
// | Ports     : i_clk   - clock                                        |
// |             i_reset - synchronous active-high reset                |
// |             i_clr   - synchronous clear                            |
// |             i_en    - count enable                                 |
// |             o_cnt   - current count                                |
// | Revision  : 1.0 - initial release                                  |
// +--------------------------------------------------------------------+
module vga_arb_sat_cnt #(
  parameter int WIDTH = 16
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_clr,
  input  logic             i_en,
  output logic [WIDTH-1:0] o_cnt
);

  logic [WIDTH-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (i_reset || i_clr) begin
      r_cnt <= '0;
    end else if (i_en && (r_cnt != {WIDTH{1'b1}})) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_cnt = r_cnt;

endmodule : vga_arb_sat_cnt
`default_nettype wire

// File: rtl/vga_ram_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module    : vga_ram_arbiter                                        |
// | Purpose   : Shares one asynchronous-read RAM between the CPU data  |
// |             bus and the VGA text controller. VGA has absolute      |
// |             priority and pre-announces each access one cycle       |
// |             ahead; CPU requests are latched and run in the next    |
// |             free RAM cycle, finished by a one-cycle ack.           |
// | Options   : VGA_ARB_STATS_EN - enables the saturating CPU stall    |
// |             counter on o_stall_cnt (otherwise tied to zero).       |
// | Ports     : i_clk/i_reset            - clock, sync active-high rst |
// |             i_cpu_* / o_cpu_*        - CPU request/response        |
// |             i_vga_* / o_vga_dat      - VGA access and read data    |
// |             o_ram_* / i_ram_dat      - RAM strobes and data        |
// |             i_stats_clr, o_stall_cnt - stall statistics            |
// | Revision  : 1.0 - initial release                                  |
// +--------------------------------------------------------------------+
module vga_ram_arbiter
  import vga_arb_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic                   i_cpu_cs,
  input  logic                   i_cpu_we,
  input  logic [AW-1:0]          i_cpu_addr,
  input  logic [DW-1:0]          i_cpu_dat,
  output logic [DW-1:0]          o_cpu_dat,
  output logic                   o_cpu_ack,
  input  logic                   i_vga_access,
  input  logic                   i_vga_cs,
  input  logic [AW-1:0]          i_vga_addr,
  output logic [DW-1:0]          o_vga_dat,
  output logic                   o_ram_cs,
  output logic                   o_ram_we,
  output logic [AW-1:0]          o_ram_addr,
  output logic [DW-1:0]          o_ram_dat,
  input  logic [DW-1:0]          i_ram_dat,
  input  logic                   i_stats_clr,
  output logic [STALL_CNT_W-1:0] o_stall_cnt
);

  cpu_state_t    r_state;
  cpu_state_t    w_state_nxt;
  logic          r_vga_grant;
  logic          r_cpu_we;
  logic [AW-1:0] r_cpu_addr;
  logic [DW-1:0] r_cpu_dat;
  logic [DW-1:0] r_cpu_rdat;
  logic          w_vga_owned;
  logic          w_cpu_go;
  logic          w_stall_inc;

  // A cycle belongs to VGA if it was announced last cycle, or if VGA
  // strobes without announcing (protocol violation still wins).
  assign w_vga_owned = r_vga_grant | i_vga_cs;
  assign w_cpu_go    = (r_state == PEND) && !w_vga_owned;
  assign w_stall_inc = (r_state == PEND) &&  w_vga_owned;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state     <= IDLE;
      r_vga_grant <= 1'b0;
      r_cpu_rdat  <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_vga_grant <= i_vga_access;
      if (w_cpu_go && !r_cpu_we) begin
        r_cpu_rdat <= i_ram_dat;
      end
    end
  end

  // Request latch; only meaningful from PEND onward, so no reset needed.
  always_ff @(posedge i_clk) begin
    if ((r_state == IDLE) && i_cpu_cs) begin
      r_cpu_we   <= i_cpu_we;
      r_cpu_addr <= i_cpu_addr;
      r_cpu_dat  <= i_cpu_dat;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    o_cpu_ack   = 1'b0;
    o_ram_cs    = 1'b0;
    o_ram_we    = 1'b0;
    o_ram_addr  = '0;
    o_ram_dat   = '0;

    case (r_state)
      IDLE: if (i_cpu_cs) w_state_nxt = PEND;
      PEND: if (!w_vga_owned) w_state_nxt = ACK;
      ACK: begin
        o_cpu_ack   = 1'b1;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase

    // VGA ownership overrides everything, so a CPU write can never
    // reach the RAM in a VGA cycle.
    if (w_vga_owned) begin
      o_ram_cs   = i_vga_cs;
      o_ram_addr = i_vga_addr;
    end else if (w_cpu_go) begin
      o_ram_cs   = 1'b1;
      o_ram_we   = r_cpu_we;
      o_ram_addr = r_cpu_addr;
      o_ram_dat  = r_cpu_dat;
    end
  end

  assign o_cpu_dat = r_cpu_rdat;
  assign o_vga_dat = i_ram_dat;

`ifdef VGA_ARB_STATS_EN
  vga_arb_sat_cnt #(
    .WIDTH (STALL_CNT_W)
  ) u_stall_cnt (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_clr   (i_stats_clr),
    .i_en    (w_stall_inc),
    .o_cnt   (o_stall_cnt)
  );
`else
  assign o_stall_cnt = '0;
  logic w_unused_stats;
  assign w_unused_stats = i_stats_clr ^ w_stall_inc;
`endif

endmodule : vga_ram_arbiter
`default_nettype wire

// File: tb/tb_vga_ram_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module    : tb_vga_ram_arbiter                                     |
// | Purpose   : Directed self-checking bench for vga_ram_arbiter with  |
// |             a behavioural async-read / sync-write RAM.             |
// |             Honours VGA_ARB_STATS_EN for stall count expectations. |
// | Revision  : 1.0 - initial release                                  |
// +--------------------------------------------------------------------+
module tb_vga_ram_arbiter;

`ifdef VGA_ARB_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_cs, cpu_we;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_wdat, cpu_rdat;
  logic        cpu_ack;
  logic        vga_access, vga_cs;
  logic [15:0] vga_addr;
  logic [7:0]  vga_dat;
  logic        ram_cs, ram_we;
  logic [15:0] ram_addr;
  logic [7:0]  ram_wdat, ram_rdat;
  logic        stats_clr;
  logic [15:0] stall_cnt;

  int errors = 0;
  int checks = 0;

  logic [7:0] mem [0:65535];

  always #5 clk = ~clk;

  always @(posedge clk) if (ram_cs && ram_we) mem[ram_addr] <= ram_wdat;
  assign ram_rdat = mem[ram_addr];

  vga_ram_arbiter #(.AW(16), .DW(8)) dut (
    .i_clk        (clk),
    .i_reset      (reset),
    .i_cpu_cs     (cpu_cs),
    .i_cpu_we     (cpu_we),
    .i_cpu_addr   (cpu_addr),
    .i_cpu_dat    (cpu_wdat),
    .o_cpu_dat    (cpu_rdat),
    .o_cpu_ack    (cpu_ack),
    .i_vga_access (vga_access),
    .i_vga_cs     (vga_cs),
    .i_vga_addr   (vga_addr),
    .o_vga_dat    (vga_dat),
    .o_ram_cs     (ram_cs),
    .o_ram_we     (ram_we),
    .o_ram_addr   (ram_addr),
    .o_ram_dat    (ram_wdat),
    .i_ram_dat    (ram_rdat),
    .i_stats_clr  (stats_clr),
    .o_stall_cnt  (stall_cnt)
  );

  // Inputs change just after the rising edge; outputs checked at the falling edge.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  // Issue a CPU access with VGA idle; checks the T+1 RAM cycle and T+2 ack.
  task automatic cpu_access(input logic we, input logic [15:0] a,
                            input logic [7:0] d, input logic [7:0] exp_rd);
    next_cycle();
    cpu_cs = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdat = d;
    next_cycle();                           // T+1: RAM cycle
    settle();
    checks++;
    if (ram_cs !== 1'b1 || ram_we !== we || ram_addr !== a || cpu_ack !== 1'b0) begin
      errors++;
      $display("FAIL cpu_ram_cycle: cs=%b we=%b addr=%h ack=%b, want cs=1 we=%b addr=%h ack=0",
               ram_cs, ram_we, ram_addr, cpu_ack, we, a);
    end
    next_cycle();                           // T+2: ack
    cpu_cs = 1'b0;
    settle();
    checks++;
    if (cpu_ack !== 1'b1 || cpu_rdat !== exp_rd) begin
      errors++;
      $display("FAIL cpu_ack: ack=%b dat=%h, want ack=1 dat=%h", cpu_ack, cpu_rdat, exp_rd);
    end
    next_cycle();
    settle();
    checks++;
    if (cpu_ack !== 1'b0) begin
      errors++;
      $display("FAIL ack_pulse_width: ack=%b, want 0", cpu_ack);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; cpu_cs = 0; cpu_we = 0; cpu_addr = 0; cpu_wdat = 0;
    vga_access = 0; vga_cs = 0; vga_addr = 0; stats_clr = 0;
    repeat (2) next_cycle();
    settle();
    checks++;
    if (cpu_ack !== 1'b0 || cpu_rdat !== 8'h00 || stall_cnt !== 16'h0 || ram_cs !== 1'b0 ||
        ram_we !== 1'b0 || ram_addr !== 16'h0 || ram_wdat !== 8'h0) begin
      errors++;
      $display("FAIL reset_state: ack=%b dat=%h stall=%h ram cs=%b we=%b addr=%h wd=%h, want all 0",
               cpu_ack, cpu_rdat, stall_cnt, ram_cs, ram_we, ram_addr, ram_wdat);
    end
    next_cycle();
    reset = 1'b0;
  endtask

  task automatic test_write_read();
    cpu_access(1'b1, 16'h1234, 8'hA5, 8'h00);   // write leaves read data alone
    cpu_access(1'b0, 16'h1234, 8'h00, 8'hA5);
    cpu_access(1'b1, 16'h1000, 8'h41, 8'hA5);
  endtask

  task automatic test_collision();
    logic [15:0] exp_stall;
    exp_stall = STATS ? 16'd2 : 16'd0;
    next_cycle();                              // edge T samples both
    cpu_cs = 1; cpu_we = 1; cpu_addr = 16'h2000; cpu_wdat = 8'h5A; vga_access = 1;
    next_cycle();                              // T+1
    vga_cs = 1; vga_addr = 16'h1000;
    settle();
    checks++;
    if (ram_cs !== 1'b1 || ram_we !== 1'b0 || ram_addr !== 16'h1000 || vga_dat !== 8'h41 || cpu_ack !== 1'b0) begin
      errors++;
      $display("FAIL collision_vga1: cs=%b we=%b addr=%h vdat=%h ack=%b, want 1 0 1000 41 0",
               ram_cs, ram_we, ram_addr, vga_dat, cpu_ack);
    end
    next_cycle();                              // T+2
    vga_access = 0;
    settle();
    checks++;
    if (ram_we !== 1'b0 || ram_addr !== 16'h1000 || cpu_ack !== 1'b0) begin
      errors++;
      $display("FAIL collision_vga2: we=%b addr=%h ack=%b, want 0 1000 0", ram_we, ram_addr, cpu_ack);
    end
    next_cycle();                              // T+3: CPU RAM cycle
    vga_cs = 0;
    settle();
    checks++;
    if (ram_cs !== 1'b1 || ram_we !== 1'b1 || ram_addr !== 16'h2000 || ram_wdat !== 8'h5A || cpu_ack !== 1'b0) begin
      errors++;
      $display("FAIL collision_cpu: cs=%b we=%b addr=%h wd=%h ack=%b, want 1 1 2000 5a 0",
               ram_cs, ram_we, ram_addr, ram_wdat, cpu_ack);
    end
    next_cycle();                              // T+4: ack
    cpu_cs = 0;
    settle();
    checks++;
    if (cpu_ack !== 1'b1 || stall_cnt !== exp_stall || cpu_rdat !== 8'hA5) begin
      errors++;
      $display("FAIL collision_ack: ack=%b stall=%0d dat=%h, want 1 %0d a5",
               cpu_ack, stall_cnt, cpu_rdat, exp_stall);
    end
    checks++;
    if (mem[16'h2000] !== 8'h5A) begin
      errors++;
      $display("FAIL collision_mem: mem=%h, want 5a", mem[16'h2000]);
    end
  endtask

  // Unannounced VGA strobe while a CPU write is pending: VGA still wins.
  task automatic test_passthrough_violation();
    next_cycle();
    cpu_cs = 1; cpu_we = 1; cpu_addr = 16'h3000; cpu_wdat = 8'h77;
    next_cycle();
    vga_cs = 1; vga_addr = 16'h1000;
    settle();
    checks++;
    if (vga_dat !== 8'h41 || ram_addr !== 16'h1000 || ram_cs !== 1'b1 || ram_we !== 1'b0) begin
      errors++;
      $display("FAIL passthrough: vdat=%h addr=%h cs=%b we=%b, want 41 1000 1 0",
               vga_dat, ram_addr, ram_cs, ram_we);
    end
    next_cycle();
    vga_cs = 0;
    settle();
    checks++;
    if (ram_we !== 1'b1 || ram_addr !== 16'h3000 || cpu_ack !== 1'b0) begin
      errors++;
      $display("FAIL violation_defer: we=%b addr=%h ack=%b, want 1 3000 0", ram_we, ram_addr, cpu_ack);
    end
    next_cycle();
    cpu_cs = 0;
    settle();
    checks++;
    if (cpu_ack !== 1'b1 || stall_cnt !== (STATS ? 16'd3 : 16'd0)) begin
      errors++;
      $display("FAIL violation_ack: ack=%b stall=%0d, want 1 %0d", cpu_ack, stall_cnt, STATS ? 3 : 0);
    end
  endtask

  task automatic test_reset_mid_request();
    next_cycle();
    cpu_cs = 1; cpu_we = 0; cpu_addr = 16'h1234; vga_access = 1;
    next_cycle();                              // PEND, stalled by grant
    vga_access = 0; reset = 1;
    next_cycle();
    reset = 0; cpu_cs = 0;
    settle();
    checks++;
    if (cpu_ack !== 1'b0 || cpu_rdat !== 8'h00 || ram_cs !== 1'b0 || stall_cnt !== 16'h0) begin
      errors++;
      $display("FAIL reset_mid: ack=%b dat=%h cs=%b stall=%h, want 0 00 0 0",
               cpu_ack, cpu_rdat, ram_cs, stall_cnt);
    end
    repeat (3) begin
      next_cycle();
      settle();
      checks++;
      if (cpu_ack !== 1'b0 || ram_cs !== 1'b0) begin
        errors++;
        $display("FAIL reset_dropped: ack=%b cs=%b, want 0 0", cpu_ack, ram_cs);
      end
    end
  endtask

  task automatic test_stats_saturation();
    next_cycle();
    cpu_cs = 1; cpu_we = 0; cpu_addr = 16'h1000; vga_cs = 1; vga_addr = 16'h0;
    for (int i = 1; i <= 70000; i++) begin
      next_cycle();
      settle();
      if (i == 65535 || i == 65536 || i == 70000) begin
        checks++;
        if (stall_cnt !== (STATS ? ((i == 65535) ? 16'hFFFE : 16'hFFFF) : 16'h0)) begin
          errors++;
          $display("FAIL stall_sat: cycle %0d stall=%h", i, stall_cnt);
        end
      end
      if (ram_we !== 1'b0 || cpu_ack !== 1'b0) begin
        checks++;
        errors++;
        $display("FAIL stall_hold: cycle %0d we=%b ack=%b, want 0 0", i, ram_we, cpu_ack);
      end
    end
    next_cycle();                              // clear wins over a stall cycle
    stats_clr = 1;
    next_cycle();
    stats_clr = 0; vga_cs = 0;
    settle();
    checks++;
    if (stall_cnt !== 16'h0 || ram_we !== 1'b0 || ram_addr !== 16'h1000) begin
      errors++;
      $display("FAIL stats_clr: stall=%h we=%b addr=%h, want 0 0 1000", stall_cnt, ram_we, ram_addr);
    end
    next_cycle();
    cpu_cs = 0;
    settle();
    checks++;
    if (cpu_ack !== 1'b1 || cpu_rdat !== 8'h41 || stall_cnt !== 16'h0) begin
      errors++;
      $display("FAIL stall_release: ack=%b dat=%h stall=%h, want 1 41 0", cpu_ack, cpu_rdat, stall_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_collision();
    test_passthrough_violation();
    test_reset_mid_request();
    test_stats_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_vga_ram_arbiter
`default_nettype wire
